melody_sequencer: RTL and testbench
===================================

Name: melody_sequencer

Overview:
- Sequences playback of a melody stored in a note ROM and drives one tone-generator channel (divisor plus enable).
- Each ROM word holds a note divisor and a duration in ticks. The block fetches words in order, holds each note for its duration, then advances.
- It handles rests, the end-of-song marker, looping and start/stop control.
- It sits between the note ROM and the square-wave note generator that produces ch_out.

Parameters:
- AW, 5: ROM address width; the ROM holds 2^AW words.
- DW, 16: note divisor width.
- TICK, 250000: clock cycles per duration tick; set to 2 for simulation.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  1-cycle pulse; begins playback from address 0 when idle.
- stop  input  1  1-cycle pulse; aborts playback.
- loop  input  1  level; when 1, restart at address 0 on end of song.
- rom_addr  output  AW  ROM read address.
- rom_data  input  DW+4  ROM word {dur[3:0], div[DW-1:0]}; synchronous ROM, valid 1 cycle after rom_addr.
- note_div  output  DW  divisor to the note generator.
- note_en  output  1  note generator enable; 0 means silence.
- note_strobe  output  1  1-cycle pulse when a new note or rest is loaded.
- busy  output  1  1 while not IDLE.
- done  output  1  1-cycle pulse on end of song.

Behaviour:
- Reset (asynchronous, immediate): state IDLE, ptr=0. Outputs rom_addr=0, note_div=0, note_en=0, note_strobe=0, busy=0, done=0. Prescaler and duration counter are cleared.
- Registers:
  - ptr is AW bits.
  - Prescaler counts 0..TICK-1 and is $clog2(TICK) bits wide.
  - Duration counter is 4 bits.
- FSM states: IDLE, FETCH, LOAD, PLAY.
- IDLE:
  - busy=0, note_en=0.
  - start=1 and stop=0: ptr<=0, go to FETCH.
  - start=1 and stop=1 in the same cycle: stay IDLE.
- FETCH: rom_addr<=ptr; go to LOAD on the next cycle. This is the ROM latency cycle.
- LOAD: decode rom_data.
  - dur==0 (end marker): pulse done.
    - loop=1: ptr<=0, go to FETCH; busy stays 1.
    - loop=0: go to IDLE; note_en<=0, note_div<=0.
  - dur!=0: note_div<=div, note_en<=(div!=0), duration counter<=dur, prescaler<=0, pulse note_strobe, go to PLAY.
  - div==0 is a rest: note_en=0 for the full duration.
- PLAY:
  - Each prescaler wrap (TICK cycles) decrements the duration counter.
  - When the counter reaches 0, the note has lasted exactly dur*TICK cycles from the first PLAY cycle.
  - If ptr==2^AW-1: treat as end of song, with the same handling as the end marker (done pulse, loop/idle rules), without fetching.
  - Otherwise: ptr<=ptr+1, go to FETCH.
- Between notes:
  - note_div and note_en hold the previous note's values through FETCH/LOAD, so the generator sees no glitch.
  - Inter-note overhead is exactly 2 cycles.
- stop:
  - Highest priority in FETCH, LOAD and PLAY.
  - Next state is IDLE, with note_en=0, note_div=0, busy=0.
  - No done pulse and no note_strobe in that cycle.
- start while busy is ignored.
- loop is sampled only at the end-of-song decision.
- done and note_strobe are never asserted in the same cycle.

Optional Feature:
- Macro: MELODY_SEQ_GAP_EN.
- Defined: articulation gap. For notes with dur>=2, note_en is forced to 0 during the last tick (final TICK cycles of PLAY); note_div is unchanged. Notes with dur==1 and rests are unaffected.
- Undefined: note_en stays at (div!=0) for the whole note, with no gap.

Test Plan (TICK=2, AW=5 unless noted):
- ROM [{2,100},{1,0},{0,0}], loop=0, start pulse:
  - note_strobe, then note_div=100 with note_en=1 for 4 PLAY cycles.
  - 2-cycle gap, then note_strobe; rest with note_en=0 for 2 cycles.
  - 2 cycles later done=1 for 1 cycle; busy falls the cycle after done; note_div=0.
- Same ROM, loop=1:
  - After the end marker, rom_addr returns to 0 and note_div=100 again.
  - done pulses once per pass; busy stays 1 throughout.
- stop pulse during the second PLAY cycle of the first note:
  - Next cycle note_en=0, note_div=0, busy=0.
  - done never pulses; rom_addr is not advanced.
- AW=2, ROM with 4 words {1,10},{1,20},{1,30},{1,40} and no end marker, loop=0:
  - Four note_strobes with note_div 10, 20, 30, 40.
  - done pulses after note 4; address 0 is not fetched again.
- rst asserted mid-PLAY (asynchronously, between clock edges):
  - All outputs go to 0 immediately.
  - After release the block stays IDLE until start.
  - start+stop in the same cycle keeps it IDLE; start while busy does not restart.
- MELODY_SEQ_GAP_EN defined, ROM [{3,100},{0,0}]:
  - note_en=1 for 4 cycles, then 0 for 2 cycles, while note_div stays 100.

Source files
------------

// File: rtl/melody_sequencer.sv
`default_nettype none
// =====================================================================
// Module   : melody_sequencer
// Purpose  : Steps through a note ROM and drives one tone channel.
//            Define MELODY_SEQ_GAP_EN to silence the final tick of
//            notes lasting two or more ticks.
// Revision : 1.0  initial release
// =====================================================================
module melody_sequencer #(
    parameter int AW   = 5,
    parameter int DW   = 16,
    parameter int TICK = 250000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    output logic [AW-1:0] rom_addr,
    input  logic [DW+3:0] rom_data,
    output logic [DW-1:0] note_div,
    output logic          note_en,
    output logic          note_strobe,
    output logic          busy,
    output logic          done
);

    localparam int            PW          = (TICK > 1) ? $clog2(TICK) : 1;
    localparam logic [PW-1:0] c_TICK_LAST = PW'(TICK - 1);
    localparam logic [AW-1:0] c_PTR_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_PLAY  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q,   ptr_d;
    logic [DW-1:0] div_q,   div_d;
    logic          en_q,    en_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    cnt_q,   cnt_d;
`ifdef MELODY_SEQ_GAP_EN
    logic          long_q,  long_d;
`endif

    logic [3:0]    w_dur;
    logic [DW-1:0] w_div;
    logic          w_tick_wrap;
    logic          w_note_over;
    logic          w_song_end;
    logic          w_abort;

    assign w_dur       = rom_data[DW+3:DW];
    assign w_div       = rom_data[DW-1:0];
    assign w_tick_wrap = (presc_q == c_TICK_LAST);
    assign w_note_over = w_tick_wrap && (cnt_q == 4'd1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        div_d       = div_q;
        en_d        = en_q;
        presc_d     = presc_q;
        cnt_d       = cnt_q;
`ifdef MELODY_SEQ_GAP_EN
        long_d      = long_q;
`endif
        note_strobe = 1'b0;
        done        = 1'b0;
        w_song_end  = 1'b0;
        w_abort     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    ptr_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (stop) w_abort = 1'b1;
                else      state_d = S_LOAD;
            end
            S_LOAD: begin
                if (stop) begin
                    w_abort = 1'b1;
                end else if (w_dur == 4'd0) begin
                    w_song_end = 1'b1;
                end else begin
                    div_d       = w_div;
                    en_d        = (w_div != '0);
                    cnt_d       = w_dur;
                    presc_d     = '0;
`ifdef MELODY_SEQ_GAP_EN
                    long_d      = (w_dur >= 4'd2);
`endif
                    note_strobe = 1'b1;
                    state_d     = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_abort = 1'b1;
                end else begin
                    presc_d = w_tick_wrap ? '0 : presc_q + PW'(1);
                    if (w_tick_wrap) cnt_d = cnt_q - 4'd1;
                    if (w_note_over) begin
`ifdef MELODY_SEQ_GAP_EN
                        // Keep the gap silent through FETCH/LOAD instead of re-enabling.
                        if (long_q) en_d = 1'b0;
`endif
                        if (ptr_q == c_PTR_LAST) begin
                            w_song_end = 1'b1;
                        end else begin
                            ptr_d   = ptr_q + AW'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (w_song_end) begin
            done = 1'b1;
            if (loop) begin
                ptr_d   = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                div_d   = '0;
            end
        end

        if (w_abort) begin
            state_d = S_IDLE;
            en_d    = 1'b0;
            div_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            div_q   <= '0;
            en_q    <= 1'b0;
            presc_q <= '0;
            cnt_q   <= 4'd0;
`ifdef MELODY_SEQ_GAP_EN
            long_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            div_q   <= div_d;
            en_q    <= en_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
`ifdef MELODY_SEQ_GAP_EN
            long_q  <= long_d;
`endif
        end
    end

    assign rom_addr = ptr_q;
    assign note_div = div_q;
    assign busy     = (state_q != S_IDLE);

`ifdef MELODY_SEQ_GAP_EN
    assign note_en = en_q & ~((state_q == S_PLAY) & long_q & (cnt_q == 4'd1));
`else
    assign note_en = en_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// Randomized bench for melody_sequencer: a timeline model built from the
// ROM contents predicts every output on every cycle of a playback run.
module tb_melody_sequencer;

    localparam int AW   = 5;
    localparam int DW   = 16;
    localparam int TICK = 2;
    localparam int N    = 400;
    localparam int MAXP = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [DW+3:0] rom_data;
    logic [DW-1:0] note_div;
    logic          note_en;
    logic          note_strobe;
    logic          busy;
    logic          done;

    logic [DW+3:0] rom [1<<AW];

    int n_cmp = 0;
    int n_bad = 0;
    int mk;
    int e_addr [N];
    int e_div  [N];
    int e_en   [N];
    int e_stb  [N];
    int e_busy [N];
    int e_done [N];

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    melody_sequencer #(.AW(AW), .DW(DW), .TICK(TICK)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .loop       (loop),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note_div   (note_div),
        .note_en    (note_en),
        .note_strobe(note_strobe),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic put(input int a, input int d, input int e, input int s, input int dn, input int b);
        if (mk < N) begin
            e_addr[mk] = a; e_div[mk] = d; e_en[mk] = e;
            e_stb[mk]  = s; e_done[mk] = dn; e_busy[mk] = b;
        end
        mk++;
    endtask

    // Expected outputs for cycles after the start edge, derived from the note list.
    task automatic build_model(input bit lp, input int sa);
        int p, pd, pe, dur, dv, en;
        bit run_on;
        p = 0; pd = 0; pe = 0; run_on = 1'b1; mk = 0;
        while (mk < N && run_on) begin
            put(p, pd, pe, 0, 0, 1);
            dur = int'(rom[p][DW+3:DW]);
            dv  = int'(rom[p][DW-1:0]);
            if (dur == 0) begin
                put(p, pd, pe, 0, 1, 1);
                if (lp) p = 0;
                else    run_on = 1'b0;
            end else begin
                put(p, pd, pe, 1, 0, 1);
                pd = dv;
                pe = (dv != 0) ? 1 : 0;
                for (int c = 0; c < dur * TICK; c++) begin
                    en = pe;
`ifdef MELODY_SEQ_GAP_EN
                    if (dur >= 2 && c >= (dur - 1) * TICK) en = 0;
`endif
                    put(p, pd, en, 0, (c == dur * TICK - 1 && p == MAXP) ? 1 : 0, 1);
                end
`ifdef MELODY_SEQ_GAP_EN
                if (dur >= 2) pe = 0;
`endif
                if (p == MAXP) begin
                    if (lp) p = 0;
                    else    run_on = 1'b0;
                end else begin
                    p++;
                end
            end
        end
        while (mk < N) put(p, 0, 0, 0, 0, 0);

        if (sa >= 0 && sa < N && e_busy[sa] != 0) begin
            e_stb[sa]  = 0;
            e_done[sa] = 0;
            for (int k = sa + 1; k < N; k++) begin
                e_addr[k] = e_addr[sa]; e_div[k] = 0; e_en[k] = 0;
                e_stb[k]  = 0;          e_done[k] = 0; e_busy[k] = 0;
            end
        end
    endtask

    task automatic run(input bit lp, input int sa, input int xs_in, input int ncyc, input bit park);
        int xs;
        build_model(lp, sa);
        xs = xs_in;
        if (xs >= ncyc || (xs >= 0 && e_busy[xs] == 0)) xs = -1;
        @(negedge clk);
        start = 1'b1; stop = 1'b0; loop = lp;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            start = (k == xs);
            stop  = (k == sa);
            #1;
            check("rom_addr",    k, 32'(rom_addr),    e_addr[k]);
            check("note_div",    k, 32'(note_div),    e_div[k]);
            check("note_en",     k, 32'(note_en),     e_en[k]);
            check("note_strobe", k, 32'(note_strobe), e_stb[k]);
            check("busy",        k, 32'(busy),        e_busy[k]);
            check("done",        k, 32'(done),        e_done[k]);
        end
        if (park) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, -1, 32'(rom_addr),    0);
        check({tag, "_div"},  -1, 32'(note_div),    0);
        check({tag, "_en"},   -1, 32'(note_en),     0);
        check({tag, "_stb"},  -1, 32'(note_strobe), 0);
        check({tag, "_busy"}, -1, 32'(busy),        0);
        check({tag, "_done"}, -1, 32'(done),        0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i <= MAXP; i++) rom[i] = '0;
    endtask

    task automatic basic_rom();
        clear_rom();
        rom[0] = {4'd2, 16'd100};
        rom[1] = {4'd1, 16'd0};
        rom[2] = {4'd0, 16'd0};
    endtask

    task automatic rand_rom(input bit marker);
        int d, v;
        for (int i = 0; i <= MAXP; i++) begin
            if (marker) begin
                d = $urandom_range(0, 9);
                d = (d == 0) ? 0 : ((d == 9) ? 15 : (d % 3) + 1);
            end else begin
                d = $urandom_range(1, 2);
            end
            v = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 65535));
            rom[i] = {4'(d), 16'(v)};
        end
    endtask

    initial begin
        clear_rom();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        basic_rom();
        run(1'b0, -1, -1, 40, 1'b1);
        run(1'b1, -1, -1, 60, 1'b1);
        run(1'b0,  3, -1, 20, 1'b1);
        run(1'b0, -1,  6, 40, 1'b1);

        clear_rom();
        rom[0] = {4'd3, 16'd100};
        run(1'b0, -1, -1, 20, 1'b1);

        for (int i = 0; i <= MAXP; i++) rom[i] = {4'd1, 16'(10 * (i + 1))};
        run(1'b0, -1, -1, 150, 1'b1);
        run(1'b1, -1, -1, 200, 1'b1);

        repeat (12) begin
            rand_rom($urandom_range(0, 3) != 0);
            run(1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1,
                int'($urandom_range(0, N - 1)), N, 1'b1);
        end

        // Asynchronous reset while the first note is playing.
        basic_rom();
        run(1'b1, -1, -1, 5, 1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("idle_busy", -1, 32'(busy),    0);
            check("idle_en",   -1, 32'(note_en), 0);
        end
        @(negedge clk);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        #1 check("startstop_busy", -1, 32'(busy), 0);
        @(negedge clk);
        #1 check("startstop_busy2", -1, 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
